// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - LEGv8 ID stage: register file with writeback bypass, immediate extraction,
// load-use bubble insertion and a valid/ready ID/EX output register.
module decode_stage_pipe #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_opcode,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_dest,
  output logic [REG_AW-1:0] out_src1,
  output logic [REG_AW-1:0] out_src2,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              hazard_stall
);

  localparam logic [REG_AW-1:0] ZR       = REG_AW'(ZERO_REG);
  localparam logic [10:0]       OP_LDUR  = 11'b11111000010;
  localparam logic [10:0]       OP_STUR  = 11'b11111000000;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              out_valid_q, out_valid_d;
  logic [10:0]       out_opcode_q, out_opcode_d;
  logic [DATA_W-1:0] out_rd1_q, out_rd1_d;
  logic [DATA_W-1:0] out_rd2_q, out_rd2_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [REG_AW-1:0] out_dest_q, out_dest_d;
  logic [REG_AW-1:0] out_src1_q, out_src1_d;
  logic [REG_AW-1:0] out_src2_q, out_src2_d;
  logic              out_mem_read_q, out_mem_read_d;
  logic              out_mem_write_q, out_mem_write_d;

  logic [10:0]       opcode;
  logic [REG_AW-1:0] src1, src2, dest;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic              mem_read, mem_write;
  logic              adv, haz;

  assign opcode    = instruction[31:21];
  assign src1      = REG_AW'(instruction[9:5]);
  assign src2      = instruction[28] ? REG_AW'(instruction[4:0]) : REG_AW'(instruction[20:16]);
  assign dest      = REG_AW'(instruction[4:0]);
  assign mem_read  = (opcode == OP_LDUR);
  assign mem_write = (opcode == OP_STUR);

  // regs_d already carries this cycle's writeback, so reading it gives the bypass for free.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_reg != ZR) regs_d[wb_reg] = wb_data;
  end

  assign rd1 = (src1 == ZR) ? '0 : regs_d[src1];
  assign rd2 = (src2 == ZR) ? '0 : regs_d[src2];

  always_comb begin
    imm = '0;
    if (instruction[31:26] == 6'b000101)
      imm = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
    else if (instruction[31:25] == 7'b1011010)
      imm = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
    else if (instruction[31:24] == 8'b11111000)
      imm = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    else if (instruction[31:22] == 10'b1001000100 || instruction[31:22] == 10'b1101000100)
      imm = {{(DATA_W-12){1'b0}}, instruction[21:10]};
  end

  assign adv = !out_valid_q || out_ready;
  assign haz = out_valid_q && out_mem_read_q && (out_dest_q != ZR) && in_valid
            && ((out_dest_q == src1) || (out_dest_q == src2));

  assign in_ready     = (adv && !haz) || flush;
  assign hazard_stall = haz && adv && !flush;

  always_comb begin
    out_valid_d     = out_valid_q;
    out_opcode_d    = out_opcode_q;
    out_rd1_d       = out_rd1_q;
    out_rd2_d       = out_rd2_q;
    out_imm_d       = out_imm_q;
    out_dest_d      = out_dest_q;
    out_src1_d      = out_src1_q;
    out_src2_d      = out_src2_q;
    out_mem_read_d  = out_mem_read_q;
    out_mem_write_d = out_mem_write_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv && haz) begin
      out_valid_d = 1'b0;
    end else if (adv && in_valid) begin
      out_valid_d     = 1'b1;
      out_opcode_d    = opcode;
      out_rd1_d       = rd1;
      out_rd2_d       = rd2;
      out_imm_d       = imm;
      out_dest_d      = dest;
      out_src1_d      = src1;
      out_src2_d      = src2;
      out_mem_read_d  = mem_read;
      out_mem_write_d = mem_write;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      out_valid_q     <= 1'b0;
      out_opcode_q    <= '0;
      out_rd1_q       <= '0;
      out_rd2_q       <= '0;
      out_imm_q       <= '0;
      out_dest_q      <= '0;
      out_src1_q      <= '0;
      out_src2_q      <= '0;
      out_mem_read_q  <= 1'b0;
      out_mem_write_q <= 1'b0;
    end else begin
      regs_q          <= regs_d;
      out_valid_q     <= out_valid_d;
      out_opcode_q    <= out_opcode_d;
      out_rd1_q       <= out_rd1_d;
      out_rd2_q       <= out_rd2_d;
      out_imm_q       <= out_imm_d;
      out_dest_q      <= out_dest_d;
      out_src1_q      <= out_src1_d;
      out_src2_q      <= out_src2_d;
      out_mem_read_q  <= out_mem_read_d;
      out_mem_write_q <= out_mem_write_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = out_opcode_q;
  assign out_rd1       = out_rd1_q;
  assign out_rd2       = out_rd2_q;
  assign out_imm       = out_imm_q;
  assign out_dest      = out_dest_q;
  assign out_src1      = out_src1_q;
  assign out_src2      = out_src2_q;
  assign out_mem_read  = out_mem_read_q;
  assign out_mem_write = out_mem_write_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed bench for decode_stage_pipe with an expected-entry scoreboard.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic        out_mem_read, out_mem_write, hazard_stall;
  logic [31:0] instruction;
  logic [4:0]  wb_reg, out_dest, out_src1, out_src2;
  logic [63:0] wb_data, out_rd1, out_rd2, out_imm;
  logic [10:0] out_opcode;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_dest(out_dest),
    .out_src1(out_src1), .out_src2(out_src2), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic [10:0] op;
    logic [63:0] rd1, rd2, imm;
    logic [4:0]  dest, src1, src2;
    logic        mr, mw;
  } entry_t;

  entry_t sb_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;

  function automatic logic [31:0] r_type(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] d_type(input logic [10:0] op, input logic [8:0] imm9, input logic [4:0] rn, rt);
    return {op, imm9, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] addi(input logic [11:0] imm12, input logic [4:0] rn, rd);
    return {10'b1001000100, imm12, rn, rd};
  endfunction
  function automatic logic [31:0] b_type(input logic [25:0] imm26);
    return {6'b000101, imm26};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [63:0] rd1, rd2, imm,
                      input logic [4:0] dest, src1, src2, input logic mr, mw);
    entry_t e;
    e = {ins[31:21], rd1, rd2, imm, dest, src1, src2, mr, mw};
    sb_q.push_back(e);
  endtask

  // Inputs are driven 1 time unit after a rising edge; handshakes are judged just before the next one.
  task automatic tick();
    entry_t obs, exp;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      obs = {out_opcode, out_rd1, out_rd2, out_imm, out_dest, out_src1, out_src2,
             out_mem_read, out_mem_write};
      n_assert++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=0x%0h expected=no entry", obs);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        n_assert++;
        assert (obs === exp) else begin
          n_fail++;
          $error("FAIL sb_entry observed=0x%0h expected=0x%0h", obs, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ins;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'hDEAD;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_rd1", out_rd1, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_mem_read", out_mem_read, 0);

    // X5 was written only under reset; X31 write and same-cycle bypass must both be dropped.
    rst_n = 1'b1;
    ins = r_type(ADD, 5'd31, 5'd5, 5'd0);
    in_valid = 1'b1; instruction = ins; wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'hFF;
    #1 chk("a_in_ready", in_ready, 1);
    push(ins, 0, 0, 0, 5'd0, 5'd5, 5'd31, 0, 0);
    tick();
    chk("a_out_valid", out_valid, 1);

    ins = r_type(ADD, 5'd31, 5'd31, 5'd2);
    instruction = ins; wb_reg = 5'd4; wb_data = 64'd7;
    push(ins, 0, 0, 0, 5'd2, 5'd31, 5'd31, 0, 0);
    tick();

    ins = r_type(ADD, 5'd4, 5'd3, 5'd1);
    instruction = ins; wb_reg = 5'd3; wb_data = 64'h1234;
    push(ins, 64'h1234, 64'd7, 0, 5'd1, 5'd3, 5'd4, 0, 0);
    tick();

    // Load-use: LDUR X2 followed by a reader of X2 costs exactly one bubble.
    ins = d_type(LDUR, 9'h1F0, 5'd1, 5'd2);
    instruction = ins; wb_reg = 5'd6; wb_data = 64'h66;
    push(ins, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 5'd2, 5'd1, 5'd2, 1, 0);
    tick();
    ins = r_type(ADD, 5'd6, 5'd2, 5'd5);
    instruction = ins; wb_en = 1'b0;
    #1 chk("lu_hazard", hazard_stall, 1);
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_bubble_valid", out_valid, 0);
    #1 chk("lu_hazard_clear", hazard_stall, 0);
    chk("lu_in_ready_back", in_ready, 1);
    push(ins, 0, 64'h66, 0, 5'd5, 5'd2, 5'd6, 0, 0);
    tick();
    chk("lu_add_valid", out_valid, 1);

    ins = d_type(LDUR, 9'h0, 5'd1, 5'd2);
    instruction = ins; wb_en = 1'b1; wb_reg = 5'd7; wb_data = 64'h77;
    push(ins, 0, 0, 0, 5'd2, 5'd1, 5'd2, 1, 0);
    tick();
    ins = r_type(ADD, 5'd6, 5'd7, 5'd5);
    instruction = ins; wb_en = 1'b0;
    #1 chk("nh_hazard", hazard_stall, 0);
    chk("nh_in_ready", in_ready, 1);
    push(ins, 64'h77, 64'h66, 0, 5'd5, 5'd7, 5'd6, 0, 0);
    tick();
    chk("nh_add_valid", out_valid, 1);

    // Backpressure: ADDI held for 3 cycles while B waits at the input.
    ins = addi(12'hFFF, 5'd31, 5'd8);
    instruction = ins;
    push(ins, 0, 0, 64'hFFF, 5'd8, 5'd31, 5'd8, 0, 0);
    tick();
    ins = b_type(26'h3FF_FFFF);
    instruction = ins; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_opcode", out_opcode, 11'b10010001001);
      chk("bp_imm", out_imm, 64'hFFF);
      chk("bp_dest", out_dest, 8);
    end
    out_ready = 1'b1;
    push(ins, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 5'd31, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 0);

    // Flush kills the held entry and the incoming one; the writeback still lands.
    in_valid = 1'b1; instruction = r_type(ADD, 5'd4, 5'd3, 5'd9);
    tick();
    out_ready = 1'b0; flush = 1'b1; instruction = r_type(ADD, 5'd3, 5'd3, 5'd12);
    wb_en = 1'b1; wb_reg = 5'd10; wb_data = 64'h55;
    #1 chk("fl_in_ready", in_ready, 1);
    chk("fl_hazard", hazard_stall, 0);
    tick();
    flush = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    ins = r_type(ADD, 5'd31, 5'd10, 5'd11);
    instruction = ins;
    push(ins, 64'h55, 0, 0, 5'd11, 5'd10, 5'd31, 0, 0);
    tick();

    // Reset during a load-use stall drops everything; the waiting ADD is accepted right after.
    ins = d_type(LDUR, 9'h0, 5'd1, 5'd2);
    instruction = ins;
    push(ins, 0, 0, 0, 5'd2, 5'd1, 5'd2, 1, 0);
    tick();
    ins = r_type(ADD, 5'd6, 5'd2, 5'd5);
    instruction = ins; rst_n = 1'b0;
    #1 chk("rs_hazard", hazard_stall, 1);
    tick();
    chk("rs_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1 chk("rs_in_ready", in_ready, 1);
    chk("rs_hazard_clear", hazard_stall, 0);
    push(ins, 0, 0, 0, 5'd5, 5'd2, 5'd6, 0, 0);
    tick();
    chk("rs_add_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    tick();
    chk("end_out_valid", out_valid, 0);
    chk("end_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
